// File: rtl/arcade_pause_ctl_if.sv
// Pause-controller signal bundle between the core/OSD side and arcade_pause_ctl.
// The master drives button, requests, OSD state, options and pixels; the slave returns the registered outputs.
interface arcade_pause_ctl_if #(
    parameter int RW   = 4,
    parameter int GW   = 4,
    parameter int BW   = 4,
    parameter int NREQ = 1
);
    logic                  user_button;
    logic [NREQ-1:0]       pause_request;
    logic                  OSD_STATUS;
    logic [1:0]            options;
    logic [RW-1:0]         r;
    logic [GW-1:0]         g;
    logic [BW-1:0]         b;
    logic [RW+GW+BW-1:0]   rgb_out;
    logic                  pause_cpu;
    logic                  dim_active;

    modport master (
        output user_button, pause_request, OSD_STATUS, options, r, g, b,
        input  rgb_out, pause_cpu, dim_active
    );

    modport slave (
        input  user_button, pause_request, OSD_STATUS, options, r, g, b,
        output rgb_out, pause_cpu, dim_active
    );
endinterface

// File: rtl/arcade_pause_ctl.sv
// Arcade pause controller: button/request/OSD pause with screen dimming after a sustained pause.
// All outputs registered with 1-cycle latency; no backpressure, outputs update every cycle.
module arcade_pause_ctl #(
    parameter int RW          = 4,
    parameter int GW          = 4,
    parameter int BW          = 4,
    parameter int NREQ        = 1,
    parameter int CLOCK_HZ    = 36000000,
    parameter int DIM_SECONDS = 10,
    parameter int DIM_SHIFT   = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    arcade_pause_ctl_if.slave    bus
);
    localparam int          PW       = $clog2(CLOCK_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLOCK_HZ - 1);
    localparam logic [7:0]  SEC_LAST = 8'(DIM_SECONDS);
    localparam logic        DIM_EN   = (DIM_SHIFT > 0);

    logic                   user_paused;
    logic                   btn_q;
    logic                   armed;
    logic [PW-1:0]          prescale;
    logic [7:0]             seconds;
    logic                   pause_cpu_q;
    logic                   dim_q;
    logic [RW+GW+BW-1:0]    rgb_q;

    logic                   user_paused_nxt;
    logic                   qual_nxt;
    logic                   dim_nxt;
    logic [PW-1:0]          prescale_nxt;
    logic [7:0]             seconds_nxt;
    logic [RW-1:0]          r_dim;
    logic [GW-1:0]          g_dim;
    logic [BW-1:0]          b_dim;

    // Shifting by the channel width or more naturally yields zero for that channel.
    assign r_dim = bus.r >> DIM_SHIFT;
    assign g_dim = bus.g >> DIM_SHIFT;
    assign b_dim = bus.b >> DIM_SHIFT;

    always_comb begin
        // armed blocks edge detection on the first clock after reset, so a held button cannot toggle
        user_paused_nxt = user_paused ^ (armed & bus.user_button & ~btn_q);
        qual_nxt        = user_paused_nxt | (bus.options[0] & bus.OSD_STATUS);
        prescale_nxt    = '0;
        seconds_nxt     = '0;
        if (qual_nxt) begin
            if (prescale == PRE_LAST) begin
                prescale_nxt = '0;
                seconds_nxt  = (seconds >= SEC_LAST) ? seconds : seconds + 8'd1;
            end else begin
                prescale_nxt = prescale + 1'b1;
                seconds_nxt  = seconds;
            end
        end
        dim_nxt = DIM_EN & qual_nxt & bus.options[1] & (seconds == SEC_LAST);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            user_paused <= 1'b0;
            btn_q       <= 1'b0;
            armed       <= 1'b0;
            prescale    <= '0;
            seconds     <= '0;
            pause_cpu_q <= 1'b0;
            dim_q       <= 1'b0;
            rgb_q       <= '0;
        end else begin
            user_paused <= user_paused_nxt;
            btn_q       <= bus.user_button;
            armed       <= 1'b1;
            prescale    <= prescale_nxt;
            seconds     <= seconds_nxt;
            pause_cpu_q <= qual_nxt | (|bus.pause_request);
            dim_q       <= dim_nxt;
            rgb_q       <= dim_nxt ? {r_dim, g_dim, b_dim} : {bus.r, bus.g, bus.b};
        end
    end

    assign bus.pause_cpu  = pause_cpu_q;
    assign bus.dim_active = dim_q;
    assign bus.rgb_out    = rgb_q;
endmodule

// File: tb/tb_arcade_pause_ctl.sv
// Bench for arcade_pause_ctl: a dimming build and a DIM_SHIFT=0 build driven in parallel,
// checked every cycle against a cycle-count model plus hand-computed literals.
module tb_arcade_pause_ctl;
    localparam int CHZ  = 8;
    localparam int DSEC = 2;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic       btn     = 1'b0;
    logic [0:0] preq    = 1'b0;
    logic       osd     = 1'b0;
    logic [1:0] opt     = 2'b00;
    logic [3:0] r = 4'h0, g = 4'h0, b = 4'h0;

    always #5 clk_sys = ~clk_sys;

    arcade_pause_ctl_if #(.RW(4), .GW(4), .BW(4), .NREQ(1)) bus1 ();
    arcade_pause_ctl_if #(.RW(4), .GW(4), .BW(4), .NREQ(1)) bus0 ();

    assign bus1.user_button = btn;   assign bus0.user_button = btn;
    assign bus1.pause_request = preq; assign bus0.pause_request = preq;
    assign bus1.OSD_STATUS = osd;    assign bus0.OSD_STATUS = osd;
    assign bus1.options = opt;       assign bus0.options = opt;
    assign bus1.r = r;  assign bus1.g = g;  assign bus1.b = b;
    assign bus0.r = r;  assign bus0.g = g;  assign bus0.b = b;

    arcade_pause_ctl #(.RW(4), .GW(4), .BW(4), .NREQ(1), .CLOCK_HZ(CHZ),
                       .DIM_SECONDS(DSEC), .DIM_SHIFT(1))
        dut1 (.clk_sys(clk_sys), .reset(rst), .bus(bus1));

    arcade_pause_ctl #(.RW(4), .GW(4), .BW(4), .NREQ(1), .CLOCK_HZ(CHZ),
                       .DIM_SECONDS(DSEC), .DIM_SHIFT(0))
        dut0 (.clk_sys(clk_sys), .reset(rst), .bus(bus0));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count consecutive qualifying-pause cycles; whole seconds = count / CLOCK_HZ.
    bit          m_up, m_prev, m_armed;
    int          m_qcyc;
    logic        m_pause, m_dim;
    logic [11:0] m_rgb, m_rgb0;

    function automatic int secs(input int c);
        int s;
        s = c / CHZ;
        return (s > DSEC) ? DSEC : s;
    endfunction

    initial forever begin
        bit q;
        @(posedge clk_sys or posedge rst);
        if (rst) begin
            m_up = 0; m_prev = 0; m_armed = 0; m_qcyc = 0;
            m_pause = 0; m_dim = 0; m_rgb = '0; m_rgb0 = '0;
        end else begin
            if (m_armed && btn && !m_prev) m_up = !m_up;
            m_prev  = btn;
            m_armed = 1;
            q       = m_up || (opt[0] && osd);
            m_pause = q || (preq != 0);
            m_dim   = q && opt[1] && (secs(m_qcyc) == DSEC);
            m_qcyc  = q ? ((m_qcyc < 1000) ? m_qcyc + 1 : m_qcyc) : 0;
            m_rgb   = m_dim ? {1'b0, r[3:1], 1'b0, g[3:1], 1'b0, b[3:1]} : {r, g, b};
            m_rgb0  = {r, g, b};
        end
    end

    initial forever begin
        @(negedge clk_sys);
        chk("pause1", {11'd0, bus1.pause_cpu},  {11'd0, m_pause});
        chk("dim1",   {11'd0, bus1.dim_active}, {11'd0, m_dim});
        chk("rgb1",   bus1.rgb_out,             m_rgb);
        chk("pause0", {11'd0, bus0.pause_cpu},  {11'd0, m_pause});
        chk("dim0",   {11'd0, bus0.dim_active}, 12'd0);
        chk("rgb0",   bus0.rgb_out,             rst ? 12'd0 : m_rgb0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        r = 4'hF; g = 4'h8; b = 4'h3; opt = 2'b10;
        step(2);
        chk("rst_pause", {11'd0, bus1.pause_cpu}, 12'd0);
        chk("rst_dim",   {11'd0, bus1.dim_active}, 12'd0);
        chk("rst_rgb",   bus1.rgb_out, 12'd0);
        rst = 1'b0;
        step(2);

        // one-cycle pulse pauses; dim after 16 paused cycles plus one
        btn = 1'b1; step(1); btn = 1'b0;
        chk("pulse_pause", {11'd0, bus1.pause_cpu}, 12'd1);
        chk("pulse_rgb", bus1.rgb_out, 12'hF83);
        step(15);
        chk("dim_early", {11'd0, bus1.dim_active}, 12'd0);
        step(1);
        chk("dim_on", {11'd0, bus1.dim_active}, 12'd1);
        chk("dim_rgb", bus1.rgb_out, 12'h741);
        chk("model_dim", {11'd0, m_dim}, 12'd1);
        chk("model_rgb", m_rgb, 12'h741);
        chk("noshift_rgb", bus0.rgb_out, 12'hF83);
        r = 4'hA; g = 4'h5; b = 4'h1; step(1);
        chk("dim_rgb2", bus1.rgb_out, 12'h520);
        r = 4'hF; g = 4'h8; b = 4'h3;

        // second pulse unpauses and clears counters
        btn = 1'b1; step(1); btn = 1'b0;
        chk("unp_pause", {11'd0, bus1.pause_cpu}, 12'd0);
        chk("unp_dim", {11'd0, bus1.dim_active}, 12'd0);
        chk("unp_rgb", bus1.rgb_out, 12'hF83);
        chk("unp_sec", {4'd0, dut1.seconds}, 12'd0);
        step(1);

        // external request pauses but never dims
        preq = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            chk("req_pause", {11'd0, bus1.pause_cpu}, 12'd1);
        end
        chk("req_dim", {11'd0, bus1.dim_active}, 12'd0);
        preq = 1'b0; step(1);
        chk("req_off", {11'd0, bus1.pause_cpu}, 12'd0);

        // OSD pause, with button toggled on and off mid-count
        osd = 1'b1; opt = 2'b00; step(2);
        chk("osd_noen", {11'd0, bus1.pause_cpu}, 12'd0);
        opt = 2'b11; step(1);
        chk("osd_pause", {11'd0, bus1.pause_cpu}, 12'd1);
        btn = 1'b1; step(1); btn = 1'b0; step(1);
        btn = 1'b1; step(1); btn = 1'b0; step(12);
        chk("osd_dim_early", {11'd0, bus1.dim_active}, 12'd0);
        step(1);
        chk("osd_dim", {11'd0, bus1.dim_active}, 12'd1);
        chk("osd_rgb", bus1.rgb_out, 12'h741);
        opt = 2'b01; step(1);
        chk("opt1_off", {11'd0, bus1.dim_active}, 12'd0);
        chk("opt1_off_rgb", bus1.rgb_out, 12'hF83);
        step(3);
        opt = 2'b11; step(1);
        chk("opt1_back", {11'd0, bus1.dim_active}, 12'd1);
        osd = 1'b0; opt = 2'b10; step(1);
        chk("osd_off", {11'd0, bus1.pause_cpu}, 12'd0);

        // held button toggles once; reset mid-dim with button held
        btn = 1'b1; step(20);
        chk("held_pause", {11'd0, bus1.pause_cpu}, 12'd1);
        chk("held_dim", {11'd0, bus1.dim_active}, 12'd1);
        #2 rst = 1'b1; #1;
        chk("arst_pause", {11'd0, bus1.pause_cpu}, 12'd0);
        chk("arst_dim", {11'd0, bus1.dim_active}, 12'd0);
        chk("arst_rgb", bus1.rgb_out, 12'd0);
        step(2); rst = 1'b0; step(3);
        chk("rel_held", {11'd0, bus1.pause_cpu}, 12'd0);
        btn = 1'b0; step(1); btn = 1'b1; step(1); btn = 1'b0;
        chk("rel_pulse", {11'd0, bus1.pause_cpu}, 12'd1);
        step(40);
        chk("s0_dim", {11'd0, bus0.dim_active}, 12'd0);
        chk("s0_rgb", bus0.rgb_out, 12'hF83);
        chk("s1_dim", {11'd0, bus1.dim_active}, 12'd1);
        btn = 1'b1; step(1); btn = 1'b0; step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arcade_pause_ctl.md
ARCADE_PAUSE_CTL -- requirements
Module: arcade_pause_ctl

Interface
REQ-001 Parameter RW, default 4, red channel width in bits (1..8).
REQ-002 Parameter GW, default 4, green channel width in bits (1..8).
REQ-003 Parameter BW, default 4, blue channel width in bits (1..8).
REQ-004 Parameter NREQ, default 1, number of external pause-request sources (1..8).
REQ-005 Parameter CLOCK_HZ, default 36000000, clk_sys cycles per one-second tick (>=2).
REQ-006 Parameter DIM_SECONDS, default 10, whole seconds of qualifying pause before dimming (1..255).
REQ-007 Parameter DIM_SHIFT, default 1, right-shift applied to each colour channel when dimmed; 0 disables dimming.
REQ-008 clk_sys  in  1  system clock, all logic on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 user_button  in  1  player pause button, synchronous to clk_sys, active high.
REQ-011 pause_request  in  NREQ  external pause requests (e.g. hiscore save/load), level-sensitive, active high.
REQ-012 OSD_STATUS  in  1  OSD menu open, synchronous, active high.
REQ-013 options  in  2  bit0 = pause while OSD open enable; bit1 = dim enable.
REQ-014 r / g / b  in  RW / GW / BW  pixel colour from core.
REQ-015 rgb_out  out  RW+GW+BW  {r,g,b} after optional dim, registered.
REQ-016 pause_cpu  out  1  registered CPU halt request.
REQ-017 dim_active  out  1  registered, high while dimming applied.

Function
REQ-018 user_paused flag SHALL toggle on each rising edge of user_button (edge = current high, previous-cycle sample low); held level SHALL NOT retoggle.
REQ-019 pause_cpu SHALL equal, one cycle after inputs, user_paused OR any pause_request bit OR (options[0] AND OSD_STATUS).
REQ-020 Qualifying pause = user_paused OR (options[0] AND OSD_STATUS); pause_request alone SHALL NOT qualify.
REQ-021 Prescaler counts 0..CLOCK_HZ-1 while qualifying pause true, wraps to 0 and emits one-cycle tick on reaching CLOCK_HZ-1.
REQ-022 Seconds counter (8-bit) increments per tick, saturates at DIM_SECONDS, never wraps.
REQ-023 Prescaler and seconds counter SHALL clear to 0 in the cycle qualifying pause is false.
REQ-024 dim_active SHALL assert the cycle after seconds counter equals DIM_SECONDS with options[1]=1 and DIM_SHIFT>0; deasserts the cycle after any of these fails.
REQ-025 options[1] cleared while counting SHALL NOT reset the counter; re-setting it while saturated re-asserts dim_active next cycle.
REQ-026 rgb_out SHALL be registered with one-cycle latency: {r,g,b} when dim_active=0, else each channel logically shifted right by DIM_SHIFT (zero fill, per-channel width preserved); DIM_SHIFT >= channel width yields 0 for that channel.
REQ-027 rgb_out latency SHALL be identical in dimmed and undimmed modes; dim_active and rgb_out change on the same edge.
REQ-028 Simultaneous button edge and pause_request: toggle applies; pause_cpu stays high while any source active.
REQ-029 Unpause by button while OSD pause still qualifies: counters keep running, no restart.

Reset
REQ-030 While reset high: user_paused=0, button sample=0, prescaler=0, seconds=0, pause_cpu=0, dim_active=0, rgb_out=0.
REQ-031 Reset asserted mid-pause or mid-dim SHALL clear all state immediately (asynchronously); first button edge is recognised no earlier than second clk_sys edge after reset release.
REQ-032 Button held high through reset release SHALL NOT produce a toggle.

Verification (CLOCK_HZ=8, DIM_SECONDS=2, DIM_SHIFT=1, 4/4/4)
REQ-033 button pulse 1 cycle, options=2'b10, rgb {F,8,3} -> pause_cpu=1 next cycle; dim_active=1 after 16 paused cycles (+1); rgb_out={7,4,1}.
REQ-034 second button pulse while dimmed -> pause_cpu=0, dim_active=0, rgb_out={F,8,3} next cycle; counters 0.
REQ-035 pause_request[0]=1 for 40 cycles, no button -> pause_cpu=1 throughout, dim_active never 1, rgb_out passthrough.
REQ-036 OSD_STATUS=1 with options=2'b00 -> pause_cpu=0; options=2'b11 -> pause_cpu=1, dim after 16 cycles.
REQ-037 button held high 20 cycles -> exactly one toggle; reset pulse during dim -> all outputs 0 immediately, no toggle on release with button high.
REQ-038 DIM_SHIFT=0 build, 40 paused cycles -> dim_active stays 0, rgb_out equals input.
